// File: rtl/bfp16_route_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bfp16_route_sched
//
// Sequencer for the BFP16 1-to-2 demux in the matmul operand loader. A single
// valid/ready stream of BFP16 words is split into two bursts. The first len0
// words go to channel 0 (A-operand buffer). The next len1 words go to
// channel 1 (B-operand buffer). Each output channel has a one-entry register
// slice, so consumer back-pressure is honoured without losing words. The two
// slices drain independently. As a result, channel 0 may still be holding its
// last word while channel 1 is already accepting input.
//
// Parameters
//   DATA_TYPE : BFP16 word width (16)
//   CNT_W     : width of the length fields and word counters. The maximum
//               burst is 2^CNT_W-1 words.
//
// Ports
//   clk, rst           : clock (rising edge) and asynchronous active-high reset
//   start, len0, len1  : job request. It is sampled only while idle, and the
//                        lengths are latched when the request is accepted.
//   busy               : high while a job is in progress (ROUTE0/ROUTE1/DRAIN)
//   done               : one-cycle pulse after every word has been delivered
//   sel                : current routing target (0 = channel 0, 1 = channel 1)
//   in_valid/ready/data: input word stream
//   out0_*             : channel 0 register slice (valid/ready/data)
//   out1_*             : channel 1 register slice (valid/ready/data)
// ---------------------------------------------------------------------------
module bfp16_route_sched #(
    parameter int DATA_TYPE = 16,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 start,
    input  logic [CNT_W-1:0]     len0,
    input  logic [CNT_W-1:0]     len1,
    output logic                 busy,
    output logic                 done,
    output logic                 sel,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_TYPE-1:0] in_data,

    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [DATA_TYPE-1:0] out0_data,

    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [DATA_TYPE-1:0] out1_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t               state_q,      state_d;
    logic [CNT_W-1:0]     len0_q,       len0_d;
    logic [CNT_W-1:0]     len1_q,       len1_d;
    logic [CNT_W-1:0]     cnt0_q,       cnt0_d;
    logic [CNT_W-1:0]     cnt1_q,       cnt1_d;
    logic                 out0_valid_q, out0_valid_d;
    logic                 out1_valid_q, out1_valid_d;
    logic [DATA_TYPE-1:0] out0_data_q,  out0_data_d;
    logic [DATA_TYPE-1:0] out1_data_q,  out1_data_d;

    logic                 in_ready_c;
    logic                 done_c;
    logic                 load0;
    logic                 load1;

    // -----------------------------------------------------------------------
    // Next-state, counters and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement. A
        // path that leaves one unassigned would infer a latch.
        state_d    = state_q;
        len0_d     = len0_q;
        len1_d     = len1_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        in_ready_c = 1'b0;
        done_c     = 1'b0;
        load0      = 1'b0;
        load1      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len0_d = len0;
                    len1_d = len1;
                    cnt0_d = '0;
                    cnt1_d = '0;
                    // Empty bursts are skipped entirely. This means a
                    // zero-length job goes straight to DRAIN.
                    if (len0 != '0) begin
                        state_d = ROUTE0;
                    end else if (len1 != '0) begin
                        state_d = ROUTE1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            ROUTE0: begin
                // Accept a word only if the slot is empty or is emptying
                // this cycle.
                in_ready_c = !out0_valid_q || out0_ready;
                if (in_valid && in_ready_c) begin
                    load0  = 1'b1;
                    cnt0_d = cnt0_q + CNT_W'(1);
                    if (cnt0_d == len0_q) begin
                        state_d = (len1_q != '0) ? ROUTE1 : DRAIN;
                    end
                end
            end

            ROUTE1: begin
                in_ready_c = !out1_valid_q || out1_ready;
                if (in_valid && in_ready_c) begin
                    load1  = 1'b1;
                    cnt1_d = cnt1_q + CNT_W'(1);
                    if (cnt1_d == len1_q) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // The job is complete only when both slices have handed
                // their last word to the consumer.
                if (!out0_valid_q && !out1_valid_q) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register slices. A load takes priority over a drain in the same
    // cycle, so valid stays high and the data advances. Data only changes on
    // a load. It therefore stays stable under back-pressure and keeps its
    // last value after valid drops.
    // -----------------------------------------------------------------------
    always_comb begin
        out0_valid_d = load0 || (out0_valid_q && !out0_ready);
        out0_data_d  = load0 ? in_data : out0_data_q;
        out1_valid_d = load1 || (out1_valid_q && !out1_ready);
        out1_data_d  = load1 ? in_data : out1_data_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: the data slices are reset too. Their value after reset is
    // visible on the ports, so it must be a known zero rather than
    // whatever the flops powered up with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len0_q       <= '0;
            len1_q       <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here. Every flop therefore
            // samples the pre-edge value of its _d input, regardless of the
            // order of the statements.
            state_q      <= state_d;
            len0_q       <= len0_d;
            len1_q       <= len1_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Port drivers
    // -----------------------------------------------------------------------
    // sel points at channel 1 once channel 0's burst is finished or skipped.
    // It changes in the same cycle as the state change.
    assign busy       = (state_q != IDLE);
    assign sel        = (state_q == ROUTE1) || (state_q == DRAIN);
    assign done       = done_c;
    assign in_ready   = in_ready_c;
    assign out0_valid = out0_valid_q;
    assign out0_data  = out0_data_q;
    assign out1_valid = out1_valid_q;
    assign out1_data  = out1_data_q;

endmodule

// File: tb/tb_bfp16_route_sched.sv
`timescale 1ns/1ps
module tb_bfp16_route_sched;

    localparam int DW = 16;
    localparam int CW = 11;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic [CW-1:0] len0       = '0;
    logic [CW-1:0] len1       = '0;
    logic          in_valid   = 1'b0;
    logic [DW-1:0] in_data    = '0;
    logic          out0_ready = 1'b0;
    logic          out1_ready = 1'b0;

    logic          busy, done, sel, in_ready;
    logic          out0_valid, out1_valid;
    logic [DW-1:0] out0_data, out1_data;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int base_done   = 0;
    bit seen0       = 1'b0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    bfp16_route_sched #(.DATA_TYPE(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len0       (len0),
        .len1       (len1),
        .busy       (busy),
        .done       (done),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor. A transfer happens at the next rising edge whenever
    // valid && ready is seen here, so the expected word is popped and
    // compared at this point.
    always @(negedge clk) begin
        if (!rst) begin
            if (out0_valid) seen0 = 1'b1;
            if (done) done_cnt++;
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check("out0_extra_word", q0.size(), 1);
                else                check("out0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check("out1_extra_word", q1.size(), 1);
                else                check("out1_data", out1_data, q1.pop_front());
            end
        end
    end

    // Called 1 ns after a rising edge. The start request is captured on the
    // following edge.
    task automatic do_start(input logic [CW-1:0] a, input logic [CW-1:0] b);
        start = 1'b1;
        len0  = a;
        len1  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one word and waits (with a bound) for it to be accepted. The
    // expected word is pushed to the queue of the channel it must appear on.
    task automatic send_word(input int ch, input logic [DW-1:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (ch == 0) q0.push_back(d);
                else         q1.push_back(d);
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", in_ready, 1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_wait", done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        // ---------------- reset values ----------------
        @(negedge clk);
        check("rst_busy",     busy,       0);
        check("rst_done",     done,       0);
        check("rst_sel",      sel,        0);
        check("rst_in_ready", in_ready,   0);
        check("rst_out0_v",   out0_valid, 0);
        check("rst_out1_v",   out1_valid, 0);
        check("rst_out0_d",   out0_data,  0);
        check("rst_out1_d",   out1_data,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- basic split ----------------
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        base_done  = done_cnt;
        do_start(2, 2);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_sel0", sel, 0);
        @(posedge clk); #1;
        send_word(0, 16'h4040);
        send_word(0, 16'h4100);
        send_word(1, 16'h4480);
        send_word(1, 16'h3FA0);
        @(negedge clk);
        check("t1_no_done_yet", done, 0);
        check("t1_out1_last",   out1_data, 16'h3FA0);
        check("t1_sel1",        sel, 1);
        @(negedge clk);
        check("t1_done", done, 1);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_busy_low",   busy, 0);
        check("t1_done_count", done_cnt - base_done, 1);
        check("t1_q0_empty",   q0.size(), 0);
        check("t1_q1_empty",   q1.size(), 0);
        @(posedge clk); #1;

        // ---------------- back-pressure ----------------
        out0_ready = 1'b0;
        do_start(3, 0);
        send_word(0, 16'h4040);
        in_valid = 1'b1;
        in_data  = 16'h4100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_in_ready_low", in_ready,   0);
            check("t2_hold_valid",   out0_valid, 1);
            check("t2_hold_data",    out0_data,  16'h4040);
            @(posedge clk); #1;
        end
        out0_ready = 1'b1;
        send_word(0, 16'h4100);
        send_word(0, 16'h4480);
        wait_done(20);
        check("t2_q0_empty", q0.size(), 0);

        // ---------------- skip channel 0 ----------------
        seen0 = 1'b0;
        do_start(0, 3);
        @(negedge clk);
        check("t3_busy",     busy,       1);
        check("t3_sel1",     sel,        1);
        check("t3_out0_low", out0_valid, 0);
        @(posedge clk); #1;
        send_word(1, 16'h3F80);
        send_word(1, 16'h4000);
        send_word(1, 16'hC040);
        wait_done(20);
        check("t3_out0_never", seen0,     0);
        check("t3_q1_empty",   q1.size(), 0);

        // ---------------- zero-length job ----------------
        start = 1'b1;
        len0  = '0;
        len1  = '0;
        @(negedge clk);
        check("t3b_no_early_done", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t3b_done", done, 1);
        check("t3b_busy", busy, 1);
        @(negedge clk);
        check("t3b_done_pulse", done, 0);
        check("t3b_idle",       busy, 0);
        @(posedge clk); #1;

        // ---------------- overlapped drain ----------------
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        do_start(1, 1);
        send_word(0, 16'h4040);
        send_word(1, 16'h4480);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_done_waits", done,      0);
            check("t4_out0_held",  out0_data, 16'h4040);
        end
        check("t4_out1_delivered", q1.size(), 0);
        @(posedge clk); #1;
        out0_ready = 1'b1;
        @(negedge clk);
        check("t4_done_not_yet", done, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_q0_empty", q0.size(), 0);
        @(posedge clk); #1;

        // ---------------- reset mid-job ----------------
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        do_start(1, 3);
        send_word(0, 16'h4040);
        send_word(1, 16'h4480);
        @(negedge clk);
        check("t5_out1_full",  out1_valid, 1);
        check("t5_in_ready_0", in_ready,   0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_out1_v", out1_valid, 0);
        check("t5_rst_out1_d", out1_data,  0);
        check("t5_rst_out0_d", out0_data,  0);
        check("t5_rst_busy",   busy,       0);
        check("t5_rst_sel",    sel,        0);
        check("t5_rst_ready",  in_ready,   0);
        check("t5_rst_done",   done,       0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out1_ready = 1'b1;
        do_start(1, 1);
        send_word(0, 16'h4100);
        send_word(1, 16'h3FA0);
        wait_done(20);
        check("t5_q0_empty", q0.size(), 0);
        check("t5_q1_empty", q1.size(), 0);

        // ---------------- start while busy ----------------
        base_done = done_cnt;
        do_start(3, 1);
        send_word(0, 16'h4040);
        start = 1'b1;
        len0  = '0;
        len1  = '0;
        @(negedge clk);
        check("t6_still_busy", busy, 1);
        check("t6_sel0",       sel,  0);
        @(posedge clk); #1;
        start = 1'b0;
        len0  = 11'd7;
        len1  = 11'd7;
        send_word(0, 16'h4100);
        send_word(0, 16'h4480);
        send_word(1, 16'h3FA0);
        wait_done(20);
        repeat (3) @(negedge clk);
        check("t6_one_done", done_cnt - base_done, 1);
        check("t6_idle",     busy,      0);
        check("t6_q0_empty", q0.size(), 0);
        check("t6_q1_empty", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
